// File: rtl/regfile_sb.sv
// Integer register file with a pending-write scoreboard, combinational read ports,
// write-to-read bypass, and a self-zeroing clear sequence after reset.
module regfile_sb #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic [NRD*AW-1:0]     rs_addr,
    output logic [NRD*XLEN-1:0]   rs_data,
    output logic [NRD-1:0]        rs_pend,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_addr
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam logic [AW-1:0] FIRST_IDX = AW'(1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_idx_q, clr_idx_d;
    logic              clr_we;
    logic [NREGS-1:0]  pend_q, pend_d;
    logic [XLEN-1:0]   regs_q [NREGS];

    logic              run;
    logic              wr_fire;

    assign run     = (state_q == ST_RUN);
    assign ready   = run;
    assign wr_fire = run && wr_en && (wr_addr != '0);

    // Clear sequencer: walks indices 1..NREGS-1, then hands over to RUN.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first; a path
        // that leaves one unassigned would infer a latch.
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        clr_we    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we    = 1'b1;
                clr_idx_d = clr_idx_q + FIRST_IDX;
                if (clr_idx_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Scoreboard next state: release on writeback first, so a same-cycle issue wins.
    always_comb begin
        pend_d = pend_q;
        if (run) begin
            if (wr_en) begin
                pend_d[wr_addr] = 1'b0;
            end
            if (iss_en) begin
                pend_d[iss_addr] = 1'b1;
            end
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // the pre-edge values, independent of statement order.
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= FIRST_IDX;
            pend_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            pend_q    <= pend_d;
        end
    end

    // NOTE: the storage array has no reset branch; zeroing it in parallel would
    // turn it into flops with wide reset fan-out, so the clear sequencer does it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                regs_q[clr_idx_q] <= '0;
            end else if (wr_fire) begin
                regs_q[wr_addr] <= wr_data;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic          live;
        logic          hit;

        assign addr = rs_addr[i*AW +: AW];
        assign live = run && (addr != '0);
        assign hit  = wr_en && (wr_addr == addr);

        // A matching writeback both forwards its data and releases the pending bit.
        assign rs_data[i*XLEN +: XLEN] = !live ? '0 : (hit ? wr_data : regs_q[addr]);
        assign rs_pend[i]              = live && pend_q[addr] && !hit;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of two, >=4); register 0 is hardwired zero.
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL derive local parameter AW = log2(NREGS), the register address width.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port ready  output  1  high when the clear sequence is done and the file accepts traffic.
REQ-008 SHALL have port rs_addr  input  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
REQ-009 SHALL have port rs_data  output  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
REQ-010 SHALL have port rs_pend  output  NRD  per read port, high when the addressed register has an outstanding producer.
REQ-011 SHALL have port wr_en  input  1  writeback strobe.
REQ-012 SHALL have port wr_addr  input  AW  writeback destination.
REQ-013 SHALL have port wr_data  input  XLEN  writeback data.
REQ-014 SHALL have port iss_en  input  1  issue strobe; marks iss_addr pending.
REQ-015 SHALL have port iss_addr  input  AW  destination of the issued instruction.

Function
REQ-016 SHALL implement a two-state FSM, CLEAR and RUN; ready = (state == RUN).
REQ-017 In CLEAR, a clear index SHALL start at 1, zero register[index] each cycle, and increment; on the cycle it writes index NREGS-1 the FSM SHALL move to RUN, so ready rises exactly NREGS-1 cycles after rst deasserts.
REQ-018 In CLEAR, wr_en and iss_en SHALL be ignored, every rs_data SHALL read 0, and every rs_pend SHALL read 0.
REQ-019 In RUN, when wr_en=1 and wr_addr!=0, register[wr_addr] SHALL take wr_data at the clock edge.
REQ-020 Writes to address 0 SHALL be discarded; address 0 SHALL always read 0 with rs_pend 0.
REQ-021 Reads SHALL be combinational: rs_data[i] = register[rs_addr[i]].
REQ-022 Write bypass: if wr_en=1 and wr_addr==rs_addr[i]!=0 in RUN, rs_data[i] SHALL equal wr_data in the same cycle.
REQ-023 The scoreboard SHALL hold one pending bit per register 1..NREGS-1.
REQ-024 iss_en=1 with iss_addr!=0 in RUN SHALL set pending[iss_addr] at the edge.
REQ-025 wr_en=1 in RUN SHALL clear pending[wr_addr] at the edge.
REQ-026 If issue and writeback target the same register in the same cycle, set SHALL win: pending stays 1 and the data is written.
REQ-027 rs_pend[i] SHALL be pending[rs_addr[i]] AND NOT (wr_en AND wr_addr==rs_addr[i]), giving same-cycle release alongside the bypass.
REQ-028 Issue and writeback on different registers in the same cycle SHALL both take effect.
REQ-029 All read ports SHALL be independent; identical addresses on several ports SHALL return identical data and pend.

Reset
REQ-030 While rst=1 at an edge: state <= CLEAR, clear index <= 1, all pending bits <= 0; ready SHALL be 0 from the next cycle.
REQ-031 Assertion of rst during CLEAR or RUN SHALL restart the full clear sequence; register contents are unspecified until it completes.
REQ-032 Register contents SHALL not be reset in parallel; zeroing is done only by the CLEAR sequence.

Verification
REQ-033 Clear timing: deassert rst, hold all inputs 0 -> ready=0 for 31 cycles, 1 on the 32nd; every address reads 0 with rs_pend 0.
REQ-034 Write/read: in RUN write 0xDEADBEEF to x5; next cycle rs_addr[0]=5 -> rs_data[0]=0xDEADBEEF. Write 0x1234 to x0 -> x0 reads 0.
REQ-035 Bypass: wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5 with rs_addr[1]=7 in the same cycle -> rs_data[1]=0xA5A5A5A5, rs_pend[1]=0.
REQ-036 Scoreboard: issue x9 -> rs_pend=1 next cycle; same-cycle issue and writeback on x9 -> stays 1; later writeback alone -> 0.
REQ-037 Reset mid-clear: pulse rst 10 cycles into CLEAR -> ready rises 31 cycles after the second deassert; wr_en and iss_en during CLEAR leave no effect.
REQ-038 Parameter sweep: NREGS=16, NRD=3, XLEN=64 -> 15-cycle clear; all three ports read and bypass correctly.
